// File: rtl/spi_slave_regs_pkg.sv
// Shared definitions for the SPI register responder.
// Register map, FSM encoding and command-byte fields.
package spi_slave_regs_pkg;

  localparam logic [6:0] ADDR_ID        = 7'h00;
  localparam logic [6:0] ADDR_CTRL      = 7'h01;
  localparam logic [6:0] ADDR_STATUS    = 7'h02;
  localparam logic [6:0] ADDR_SCRATCH   = 7'h03;
  localparam logic [6:0] ADDR_FRAME_CNT = 7'h04;

  localparam int CMD_READ_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  function automatic logic is_writable(
    input logic [6:0] a
  );
    return (a == ADDR_CTRL) || (a == ADDR_SCRATCH);
  endfunction

endpackage

// File: rtl/spi_slave_regs_sync.sv
// N-stage synchronizer with edge pulses.
// Edges compare the last synced sample with the one before.
module sync_edge #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]             prev;

  // Shift the async input through the chain; keep one older sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder exposing a small register file.
// All SPI pins are oversampled on the fabric clock.
module spi_slave_regs
  import spi_slave_regs_pkg::*;
#(
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       FPGA_CLK1_50,
  input  logic       hps_fpga_reset_n,
  input  logic       spi_sck,
  input  logic       spi_ss_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [3:0] sw,
  input  logic [1:0] key,
  output logic [7:0] ctrl_out,
  output logic       wr_strobe,
  output logic       busy
);

  logic       sck_lvl;
  logic       sck_rise;
  logic       sck_fall;
  logic       ss_lvl;
  logic       ss_rise;
  logic       ss_fall;
  logic       mosi_s;
  logic [3:0] sw_s;
  logic [1:0] key_s;
  logic [6:0] lvl_rise;
  logic [6:0] lvl_fall;
  logic       unused_sync;

  state_t     state;
  state_t     state_nxt;
  logic       active;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sh;
  logic [7:0] rx_byte;
  logic       byte_done;
  logic       rw;
  logic [6:0] addr;
  logic       cmd_done;
  logic       wr_pend;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] tx_sh;
  logic       load_rd;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] ctrl_q;
  logic [7:0] scratch_q;
  logic [7:0] frame_cnt;

  sync_edge #(
    .STAGES(SYNC_STAGES),
    .WIDTH (1)
  ) u_sck (
    .clk  (FPGA_CLK1_50),
    .rst_n(hps_fpga_reset_n),
    .din  (spi_sck),
    .level(sck_lvl),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  sync_edge #(
    .STAGES(SYNC_STAGES),
    .WIDTH (1)
  ) u_ss (
    .clk  (FPGA_CLK1_50),
    .rst_n(hps_fpga_reset_n),
    .din  (spi_ss_n),
    .level(ss_lvl),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  sync_edge #(
    .STAGES(SYNC_STAGES),
    .WIDTH (7)
  ) u_lvl (
    .clk  (FPGA_CLK1_50),
    .rst_n(hps_fpga_reset_n),
    .din  ({spi_mosi, sw, key}),
    .level({mosi_s, sw_s, key_s}),
    .rise (lvl_rise),
    .fall (lvl_fall)
  );

  assign unused_sync = ^{sck_lvl, lvl_rise, lvl_fall};

  assign active    = (state != ST_IDLE);
  assign rx_byte   = {rx_sh, mosi_s};
  assign byte_done = active & sck_rise & (bit_cnt == 3'd7);
  assign load_rd   = byte_done &
                     ((state == ST_CMD) ? rx_byte[CMD_READ_BIT] : rw);
  assign rd_addr   = (state == ST_CMD) ? rx_byte[6:0]
                                       : addr + 7'd1;

  // FSM state register.
  always_ff @(posedge FPGA_CLK1_50) begin
    if (!hps_fpga_reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; SS rise always wins over byte progress.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (ss_fall) state_nxt = ST_CMD;
      end
      ST_CMD: begin
        if (ss_rise)        state_nxt = ST_IDLE;
        else if (byte_done) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (ss_rise) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state != ST_IDLE);
  end

  // Receive shifter and bit counter, cleared at frame boundaries.
  always_ff @(posedge FPGA_CLK1_50) begin
    if (!hps_fpga_reset_n) begin
      bit_cnt <= '0;
      rx_sh   <= '0;
    end else if (ss_fall || ss_rise) begin
      bit_cnt <= '0;
      rx_sh   <= '0;
    end else if (active && sck_rise) begin
      bit_cnt <= bit_cnt + 3'd1;
      rx_sh   <= rx_byte[6:0];
    end
  end

  // Command decode, address auto-increment and frame bookkeeping.
  always_ff @(posedge FPGA_CLK1_50) begin
    if (!hps_fpga_reset_n) begin
      rw       <= 1'b0;
      addr     <= '0;
      cmd_done <= 1'b0;
    end else begin
      if (state == ST_CMD && byte_done) begin
        rw   <= rx_byte[CMD_READ_BIT];
        addr <= rx_byte[6:0];
      end else if (state == ST_DATA && byte_done) begin
        addr <= addr + 7'd1;
      end
      if (ss_rise) begin
        cmd_done <= 1'b0;
      end else if (state == ST_CMD && byte_done) begin
        cmd_done <= 1'b1;
      end
    end
  end

  // Capture a completed write byte for commit on the next clock.
  always_ff @(posedge FPGA_CLK1_50) begin
    if (!hps_fpga_reset_n) begin
      wr_pend <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_pend <= (state == ST_DATA) && byte_done && !rw;
      if (byte_done) begin
        wr_addr <= addr;
        wr_data <= rx_byte;
      end
    end
  end

  // Writable registers; strobe only for addresses that accept data.
  always_ff @(posedge FPGA_CLK1_50) begin
    if (!hps_fpga_reset_n) begin
      ctrl_q    <= '0;
      scratch_q <= '0;
      wr_strobe <= 1'b0;
    end else begin
      wr_strobe <= wr_pend && is_writable(wr_addr);
      if (wr_pend && wr_addr == ADDR_CTRL) begin
        ctrl_q <= wr_data;
      end
      if (wr_pend && wr_addr == ADDR_SCRATCH) begin
        scratch_q <= wr_data;
      end
    end
  end

  // Count frames that got past the command byte, on SS release.
  always_ff @(posedge FPGA_CLK1_50) begin
    if (!hps_fpga_reset_n) begin
      frame_cnt <= '0;
    end else if (ss_rise &&
                 (cmd_done || (state == ST_CMD && byte_done))) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Read mux; STATUS is whatever the synced pins show at load time.
  always_comb begin
    rd_data = '0;
    unique case (rd_addr)
      ADDR_ID:        rd_data = ID_VALUE;
      ADDR_CTRL:      rd_data = ctrl_q;
      ADDR_STATUS:    rd_data = {2'b00, key_s, sw_s};
      ADDR_SCRATCH:   rd_data = scratch_q;
      ADDR_FRAME_CNT: rd_data = frame_cnt;
      default:        rd_data = '0;
    endcase
  end

  // Transmit shifter; MISO only moves on a detected SCK fall.
  always_ff @(posedge FPGA_CLK1_50) begin
    if (!hps_fpga_reset_n) begin
      tx_sh    <= '0;
      spi_miso <= 1'b0;
    end else if (ss_fall || ss_rise) begin
      tx_sh    <= '0;
      spi_miso <= 1'b0;
    end else if (load_rd) begin
      tx_sh <= rd_data;
    end else if (active && sck_fall) begin
      spi_miso <= tx_sh[7];
      tx_sh    <= {tx_sh[6:0], 1'b0};
    end
  end

  // MISO driver enable follows the synced select.
  always_ff @(posedge FPGA_CLK1_50) begin
    if (!hps_fpga_reset_n) begin
      spi_miso_oe <= 1'b0;
    end else begin
      spi_miso_oe <= !ss_lvl;
    end
  end

  assign ctrl_out = ctrl_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: table of SPI frames
// plus abort and reset-mid-frame sequences.
module tb_spi_slave_regs;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic [3:0] sw = '0;
  logic [1:0] key = '0;
  logic       miso;
  logic       oe;
  logic [7:0] ctrl;
  logic       wr_strobe;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int strobe_total = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    int              n;
    logic [3:0][7:0] tx;
    logic [3:0][7:0] rx;
    logic [3:0]      sw;
    logic [1:0]      key;
    logic [7:0]      ctrl;
    int              strobes;
  } vec_t;

  vec_t vecs[13];

  spi_slave_regs dut (
    .FPGA_CLK1_50    (clk),
    .hps_fpga_reset_n(rst_n),
    .spi_sck         (sck),
    .spi_ss_n        (ss_n),
    .spi_mosi        (mosi),
    .spi_miso        (miso),
    .spi_miso_oe     (oe),
    .sw              (sw),
    .key             (key),
    .ctrl_out        (ctrl),
    .wr_strobe       (wr_strobe),
    .busy            (busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (wr_strobe === 1'b1) strobe_total++;
  end

  function automatic vec_t mk(
    input int n,
    input logic [7:0] t0, t1, t2, t3,
    input logic [7:0] r0, r1, r2, r3,
    input logic [3:0] s,
    input logic [1:0] k,
    input logic [7:0] c,
    input int st
  );
    vec_t v;
    v.n = n;
    v.tx[0] = t0; v.tx[1] = t1;
    v.tx[2] = t2; v.tx[3] = t3;
    v.rx[0] = r0; v.rx[1] = r1;
    v.rx[2] = r2; v.rx[3] = r3;
    v.sw = s;
    v.key = k;
    v.ctrl = c;
    v.strobes = st;
    return v;
  endfunction

  task automatic check(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic spi_bits(
    input  logic [7:0] tx,
    input  int         nbits,
    output logic [7:0] rx
  );
    rx = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = miso;
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic frame_start();
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic xfer_byte(
    input string      name,
    input logic [7:0] tx,
    input logic [7:0] exp
  );
    logic [7:0] r;
    logic [7:0] e;
    exp_q.push_back(exp);
    spi_bits(tx, 8, r);
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(name, r, e);
    end
  endtask

  initial begin
    int s0;
    logic [7:0] r;

    vecs[0]  = mk(2, 8'h80, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'hA5, 8'h00, 8'h00, 4'h0, 2'h0, 8'h00, 0);
    vecs[1]  = mk(2, 8'h84, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h01, 8'h00, 8'h00, 4'h0, 2'h0, 8'h00, 0);
    vecs[2]  = mk(2, 8'h01, 8'h3C, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 2'h0, 8'h3C, 1);
    vecs[3]  = mk(2, 8'h81, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h3C, 8'h00, 8'h00, 4'h0, 2'h0, 8'h3C, 0);
    vecs[4]  = mk(3, 8'h03, 8'h11, 8'h22, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 2'h0, 8'h3C, 1);
    vecs[5]  = mk(3, 8'h83, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h11, 8'h05, 8'h00, 4'h0, 2'h0, 8'h3C, 0);
    vecs[6]  = mk(3, 8'hFF, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'hA5, 8'h00, 4'h0, 2'h0, 8'h3C, 0);
    vecs[7]  = mk(2, 8'h82, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h1A, 8'h00, 8'h00, 4'hA, 2'h1, 8'h3C, 0);
    vecs[8]  = mk(4, 8'h02, 8'h99, 8'h5A, 8'h77,
                  8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 2'h0, 8'h3C, 1);
    vecs[9]  = mk(2, 8'h83, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h5A, 8'h00, 8'h00, 4'h0, 2'h0, 8'h3C, 0);
    vecs[10] = mk(2, 8'h01, 8'hC3, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 2'h0, 8'hC3, 1);
    vecs[11] = mk(2, 8'h7F, 8'h12, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 2'h0, 8'hC3, 0);
    vecs[12] = mk(2, 8'h84, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h0C, 8'h00, 8'h00, 4'h0, 2'h0, 8'hC3, 0);

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_ctrl", ctrl, 8'h00);
    check("rst_miso", miso, 1'b0);
    check("rst_oe", oe, 1'b0);
    check("rst_strobe", wr_strobe, 1'b0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_busy", busy, 1'b0);

    foreach (vecs[v]) begin
      sw  = vecs[v].sw;
      key = vecs[v].key;
      s0  = strobe_total;
      frame_start();
      for (int b = 0; b < vecs[v].n; b++) begin
        xfer_byte($sformatf("v%0d_b%0d", v, b),
                  vecs[v].tx[b], vecs[v].rx[b]);
        if (b == 0) begin
          check($sformatf("v%0d_busy", v), busy, 1'b1);
          check($sformatf("v%0d_oe", v), oe, 1'b1);
        end
      end
      frame_end();
      check($sformatf("v%0d_ctrl", v), ctrl, vecs[v].ctrl);
      check($sformatf("v%0d_strobes", v),
            strobe_total - s0, vecs[v].strobes);
      check($sformatf("v%0d_idle", v), busy, 1'b0);
      check($sformatf("v%0d_oe_off", v), oe, 1'b0);
    end
    sw  = '0;
    key = '0;

    s0 = strobe_total;
    frame_start();
    xfer_byte("abort_cmd", 8'h01, 8'h00);
    spi_bits(8'hFF, 4, r);
    frame_end();
    check("abort_ctrl", ctrl, 8'hC3);
    check("abort_strobes", strobe_total - s0, 0);
    check("abort_idle", busy, 1'b0);
    frame_start();
    xfer_byte("after_abort_cmd", 8'h84, 8'h00);
    xfer_byte("after_abort_fcnt", 8'h00, 8'h0E);
    frame_end();

    frame_start();
    xfer_byte("rstmid_cmd", 8'h01, 8'h00);
    spi_bits(8'hF0, 3, r);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rstmid_ctrl", ctrl, 8'h00);
    check("rstmid_busy", busy, 1'b0);
    s0 = strobe_total;
    spi_bits(8'h01, 8, r);
    check("rstmid_ign_busy", busy, 1'b0);
    spi_bits(8'h77, 8, r);
    check("rstmid_ign_miso", r, 8'h00);
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    check("rstmid_ign_strobes", strobe_total - s0, 0);
    check("rstmid_ign_ctrl", ctrl, 8'h00);
    frame_start();
    xfer_byte("rstmid_rd_cmd", 8'h84, 8'h00);
    xfer_byte("rstmid_fcnt", 8'h00, 8'h00);
    frame_end();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
